// File: rtl/can_pkg.sv
// Shared CAN frame-field codes, form-checker FSM encoding and a width helper.
package can_pkg;

  localparam logic [4:0] CRC_DELIM = 5'b10001;
  localparam logic [4:0] ACK_DELIM = 5'b10010;
  localparam logic [4:0] EOF       = 5'b00101;
  localparam logic [4:0] ERR_DELIM = 5'b00110;
  localparam logic [4:0] OVL_DELIM = 5'b00111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } form_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_sync_delay.sv
// Fixed-latency delay line; every bit of the bus moves together so the
// delayed sample strobe stays aligned with its data and field code.
module can_sync_delay #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RST_VAL     = '0
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/can_form_checker.sv
// CAN form-error checker: flags dominant bits in fixed-form fields, stretches the
// error into a HOLD_CLKS pulse, and requests overload on a dominant last EOF bit.
module can_form_checker
  import can_pkg::*;
#(
  parameter int unsigned FIELD_W     = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CLKS   = 10,
  parameter int unsigned EOF_BITS    = 7,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Data,
  input  logic               i_Sample,
  input  logic [FIELD_W-1:0] i_frame_field,
  input  logic               i_Clear,
  output logic               o_form_monitor,
  output logic               o_form_sticky,
  output logic [FIELD_W-1:0] o_err_field,
  output logic               o_overload_req,
  output logic [CNT_W-1:0]   o_err_count
);

  localparam int unsigned      DW        = FIELD_W + 2;
  localparam int unsigned      EW        = cnt_bits(EOF_BITS);
  localparam int unsigned      HW        = cnt_bits(HOLD_CLKS);
  localparam logic [EW-1:0]    EOF_LAST  = EW'(EOF_BITS - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [DW-1:0]      w_sync;
  logic               w_data;
  logic               w_sample;
  logic [FIELD_W-1:0] w_field;

  // Reset leaves the line recessive with no strobe pending.
  can_sync_delay #(
    .WIDTH      (DW),
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    ({1'b1, 1'b0, {FIELD_W{1'b0}}})
  ) u_sync (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_d    ({i_Data, i_Sample, i_frame_field}),
    .o_q    (w_sync)
  );

  assign w_data   = w_sync[DW-1];
  assign w_sample = w_sync[DW-2];
  assign w_field  = w_sync[FIELD_W-1:0];

  logic [FIELD_W-1:0] r_prev_field;
  logic [EW-1:0]      r_eof_cnt;
  logic [FIELD_W-1:0] r_err_field;
  logic               r_sticky;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_err_count;
  form_state_e        r_state;
  form_state_e        w_state_nxt;
  logic [HW-1:0]      r_hold_cnt;
  logic [HW-1:0]      w_hold_cnt_nxt;

  logic          w_field_chg;
  logic [EW-1:0] w_eof_idx;
  logic          w_dom_strobe;
  logic          w_is_delim;
  logic          w_is_eof;
  logic          w_err;
  logic          w_ovl;

  // A field change restarts EOF numbering even on the strobe that enters EOF.
  assign w_field_chg  = (w_field != r_prev_field);
  assign w_eof_idx    = w_field_chg ? '0 : r_eof_cnt;
  assign w_dom_strobe = w_sample & ~w_data;
  assign w_is_eof     = (w_field == FIELD_W'(EOF));
  assign w_is_delim   = (w_field == FIELD_W'(CRC_DELIM)) || (w_field == FIELD_W'(ACK_DELIM)) ||
                        (w_field == FIELD_W'(ERR_DELIM)) || (w_field == FIELD_W'(OVL_DELIM));
  assign w_err        = w_dom_strobe & (w_is_delim | (w_is_eof & (w_eof_idx < EOF_LAST)));
  assign w_ovl        = w_dom_strobe & w_is_eof & (w_eof_idx == EOF_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_err) begin
          w_state_nxt    = ST_HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = ST_IDLE;
        else                         w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      end
    endcase
  end

  // A detection outranks i_Clear so an error in the clearing clock is never lost.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_prev_field <= '0;
      r_eof_cnt    <= '0;
      r_err_field  <= '0;
      r_sticky     <= 1'b0;
      r_ovl        <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_prev_field <= w_field;
      r_ovl        <= w_ovl;
      if (w_sample && w_is_eof)
        r_eof_cnt <= (w_eof_idx == EOF_LAST) ? EOF_LAST : w_eof_idx + 1'b1;
      else if (w_field_chg)
        r_eof_cnt <= '0;
      if (w_err && (r_state == ST_IDLE))
        r_err_field <= w_field;
      if (w_err) begin
        r_sticky <= 1'b1;
        if (i_Clear)                       r_err_count <= CNT_W'(1);
        else if (r_err_count != CNT_MAX)   r_err_count <= r_err_count + 1'b1;
      end else if (i_Clear) begin
        r_sticky    <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign o_form_monitor = (r_state == ST_HOLD);
  assign o_form_sticky  = r_sticky;
  assign o_err_field    = r_err_field;
  assign o_overload_req = r_ovl;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_can_form_checker.sv
// Randomised bench for can_form_checker with a behavioural reference model,
// plus directed scenarios whose results are pinned to hand-computed literals.
module tb_can_form_checker;

  localparam int S     = 2;
  localparam int HOLD  = 10;
  localparam int EBITS = 7;

  localparam logic [4:0] F_CRC  = 5'b10001;
  localparam logic [4:0] F_ACK  = 5'b10010;
  localparam logic [4:0] F_EOF  = 5'b00101;
  localparam logic [4:0] F_ERR  = 5'b00110;
  localparam logic [4:0] F_OVL  = 5'b00111;
  localparam logic [4:0] F_IDLE = 5'b00000;

  logic       clk;
  logic       rst;
  logic       data;
  logic       sample;
  logic [4:0] field;
  logic       clr;

  logic       mon,    mon2;
  logic       sticky, sticky2;
  logic [4:0] errField, errField2;
  logic       ovl,    ovl2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int vectors     = 0;
  int miscompares = 0;

  can_form_checker dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Data        (data),
    .i_Sample      (sample),
    .i_frame_field (field),
    .i_Clear       (clr),
    .o_form_monitor(mon),
    .o_form_sticky (sticky),
    .o_err_field   (errField),
    .o_overload_req(ovl),
    .o_err_count   (cnt)
  );

  can_form_checker #(.CNT_W(2)) dut2 (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Data        (data),
    .i_Sample      (sample),
    .i_frame_field (field),
    .i_Clear       (clr),
    .o_form_monitor(mon2),
    .o_form_sticky (sticky2),
    .o_err_field   (errField2),
    .o_overload_req(ovl2),
    .o_err_count   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isDelim(input logic [4:0] f);
    return (f == F_CRC) || (f == F_ACK) || (f == F_ERR) || (f == F_OVL);
  endfunction

  // Reference model: inputs are seen S clocks late through a history queue;
  // the monitor is a countdown of remaining high clocks.
  logic [6:0] hist[$];
  logic [6:0] mD;
  bit         modelValid = 0;
  int         mHold, mCnt, mCnt2, mEofSeen, mIdx;
  logic [4:0] mErrField, mPrevField;
  logic       mSticky, mOvl, mDom, mErr;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(7'b1000000);
      mHold = 0; mCnt = 0; mCnt2 = 0; mEofSeen = 0;
      mErrField = '0; mPrevField = '0; mSticky = 0; mOvl = 0;
      modelValid = 1;
    end else if (modelValid) begin
      mD = hist.pop_front();
      hist.push_back({data, sample, field});
      if (mD[4:0] != mPrevField) mEofSeen = 0;
      mIdx = (mEofSeen < EBITS - 1) ? mEofSeen : EBITS - 1;
      if (mD[5] && mD[4:0] == F_EOF) mEofSeen++;
      mDom = mD[5] && !mD[6];
      mErr = mDom && (isDelim(mD[4:0]) || (mD[4:0] == F_EOF && mIdx < EBITS - 1));
      mOvl = mDom && (mD[4:0] == F_EOF) && (mIdx == EBITS - 1);
      if (mHold > 0) mHold--;
      else if (mErr) begin
        mHold     = HOLD;
        mErrField = mD[4:0];
      end
      if (mErr) begin
        mSticky = 1;
        mCnt    = clr ? 1 : ((mCnt  < 255) ? mCnt  + 1 : 255);
        mCnt2   = clr ? 1 : ((mCnt2 < 3)   ? mCnt2 + 1 : 3);
      end else if (clr) begin
        mSticky = 0; mCnt = 0; mCnt2 = 0;
      end
      mPrevField = mD[4:0];
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("monitor",   mon,       mHold > 0);
      checkOutput("sticky",    sticky,    mSticky);
      checkOutput("err_field", errField,  mErrField);
      checkOutput("overload",  ovl,       mOvl);
      checkOutput("count",     cnt,       mCnt);
      checkOutput("count_w2",  cnt2,      mCnt2);
      checkOutput("sticky_w2", sticky2,   mSticky);
      checkOutput("monitor_w2", mon2,     mHold > 0);
    end
  end

  int stepIdx, monFirst, monHighCnt, ovlCnt;

  task automatic clearObs();
    stepIdx = 0; monFirst = -1; monHighCnt = 0; ovlCnt = 0;
  endtask

  task automatic applyStimulus(input logic d, input logic s, input logic [4:0] f,
                               input logic c, input logic r);
    data = d; sample = s; field = f; clr = c; rst = r;
    @(negedge clk);
    if (mon && monFirst < 0) monFirst = stepIdx;
    monHighCnt += int'(mon);
    ovlCnt     += int'(ovl);
    stepIdx++;
    #1;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
  endtask

  task automatic sendEofFrame(input int domBit);
    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
    for (int b = 0; b < EBITS; b++) begin
      applyStimulus((b == domBit) ? 1'b0 : 1'b1, 1'b1, F_EOF, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, F_EOF, 1'b0, 1'b0);
    end
    runIdle(14);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hold;
    logic [4:0] rf;
    rst = 1'b1; data = 1'b1; sample = 1'b0; field = F_IDLE; clr = 1'b0;
    clearObs();
    repeat (3) @(negedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
    checkOutput("rst_monitor", mon, 0);
    checkOutput("rst_sticky", sticky, 0);
    checkOutput("rst_count", cnt, 0);
    checkOutput("rst_field", errField, 0);
    checkOutput("rst_ovl", ovl, 0);

    // Dominant CRC delimiter: pulse starts 3 clocks after the strobe.
    clearObs();
    applyStimulus(1'b0, 1'b1, F_CRC, 1'b0, 1'b0);
    runIdle(14);
    checkOutput("crc_first_high", monFirst, 2);
    checkOutput("crc_pulse_len", monHighCnt, 10);
    checkOutput("crc_err_field", errField, 32'h11);
    checkOutput("crc_count", cnt, 1);
    checkOutput("crc_sticky", sticky, 1);

    clearObs();
    sendEofFrame(-1);
    checkOutput("eof_ok_mon", monHighCnt, 0);
    checkOutput("eof_ok_ovl", ovlCnt, 0);
    checkOutput("eof_ok_count", cnt, 1);

    clearObs();
    sendEofFrame(6);
    checkOutput("eof6_ovl", ovlCnt, 1);
    checkOutput("eof6_mon", monHighCnt, 0);
    checkOutput("eof6_count", cnt, 1);

    clearObs();
    sendEofFrame(3);
    checkOutput("eof3_mon", monHighCnt, 10);
    checkOutput("eof3_ovl", ovlCnt, 0);
    checkOutput("eof3_count", cnt, 2);
    checkOutput("eof3_field", errField, 32'h05);

    // Second error lands inside HOLD: counted but not re-triggered.
    clearObs();
    applyStimulus(1'b0, 1'b1, F_ACK, 1'b0, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, 1'b1, F_OVL, 1'b0, 1'b0);
    runIdle(16);
    checkOutput("dbl_mon", monHighCnt, 10);
    checkOutput("dbl_count", cnt, 4);
    checkOutput("dbl_field", errField, 32'h12);

    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b1, 1'b0);
    checkOutput("clear_sticky", sticky, 0);
    checkOutput("clear_count", cnt, 0);

    // Clear arrives on the very clock the delayed strobe is evaluated.
    applyStimulus(1'b0, 1'b1, F_CRC, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b1, 1'b0);
    checkOutput("clrdet_sticky", sticky, 1);
    checkOutput("clrdet_count", cnt, 1);
    checkOutput("clrdet_count_w2", cnt2, 1);
    runIdle(12);
    repeat (5) begin
      applyStimulus(1'b0, 1'b1, F_ERR, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
    end
    runIdle(14);
    checkOutput("sat_count_w2", cnt2, 3);
    checkOutput("sat_count_w8", cnt, 6);

    // Reset on the 4th hold clock aborts the pulse.
    clearObs();
    applyStimulus(1'b0, 1'b1, F_CRC, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (monHighCnt == 4) break;
      applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b0);
    end
    checkOutput("hold_reach", monHighCnt, 4);
    applyStimulus(1'b1, 1'b0, F_IDLE, 1'b0, 1'b1);
    checkOutput("abort_mon", mon, 0);
    checkOutput("abort_sticky", sticky, 0);
    checkOutput("abort_count", cnt, 0);
    checkOutput("abort_field", errField, 0);
    checkOutput("abort_ovl", ovl, 0);
    clearObs();
    applyStimulus(1'b0, 1'b1, F_CRC, 1'b0, 1'b0);
    runIdle(14);
    checkOutput("post_rst_first", monFirst, 2);
    checkOutput("post_rst_len", monHighCnt, 10);

    hold = 0;
    rf = F_IDLE;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 7))
          0:       rf = F_CRC;
          1:       rf = F_ACK;
          2, 3:    rf = F_EOF;
          4:       rf = F_ERR;
          5:       rf = F_OVL;
          default: rf = 5'($urandom_range(0, 31));
        endcase
        hold = $urandom_range(1, 16);
      end
      hold--;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rf,
                    $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0);
    end
    runIdle(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/can_form_checker.md
CAN_FORM_CHECKER -- requirements
Module: can_form_checker

Interface
REQ-001 SHALL have parameter FIELD_W, default 5, meaning frame-field code width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input delay flops (min 1).
REQ-003 SHALL have parameter HOLD_CLKS, default 10, meaning o_form_monitor assertion length in clocks (min 1).
REQ-004 SHALL have parameter EOF_BITS, default 7, meaning End-Of-Frame length in bits.
REQ-005 SHALL have parameter CNT_W, default 8, meaning error counter width.
REQ-006 SHALL have port i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_Reset, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port i_Data, input, 1, bus bit (0 = dominant).
REQ-009 SHALL have port i_Sample, input, 1, one-clock bit sample-point strobe.
REQ-010 SHALL have port i_frame_field, input, FIELD_W, current frame-field code.
REQ-011 SHALL have port i_Clear, input, 1, clears sticky flag and counter.
REQ-012 SHALL have port o_form_monitor, output, 1, form-error pulse held HOLD_CLKS clocks.
REQ-013 SHALL have port o_form_sticky, output, 1, latched "form error seen".
REQ-014 SHALL have port o_err_field, output, FIELD_W, field code of the most recent form error.
REQ-015 SHALL have port o_overload_req, output, 1, one-clock pulse on dominant last EOF bit.
REQ-016 SHALL have port o_err_count, output, CNT_W, saturating form-error count.

Function
REQ-017 SHALL delay i_Data, i_Sample and i_frame_field by SYNC_STAGES flops each, keeping them aligned.
REQ-018 SHALL evaluate only on delayed sample strobes; no check between strobes.
REQ-019 SHALL flag a form error for a dominant sampled bit in CRC delimiter (10001), ACK delimiter (10010), error delimiter (00110) or overload delimiter (00111).
REQ-020 SHALL count sampled EOF (00101) bits from 0, restarting whenever the delayed field changes.
REQ-021 SHALL flag a form error for dominant EOF bits 0..EOF_BITS-2; dominant bit EOF_BITS-1 SHALL pulse o_overload_req only.
REQ-022 SHALL not flag any error for other field codes.
REQ-023 SHALL use FSM IDLE -> HOLD on error; HOLD -> IDLE after exactly HOLD_CLKS clocks; o_form_monitor=1 iff HOLD.
REQ-024 SHALL assert o_form_monitor on the clock after the delayed strobe, i.e. SYNC_STAGES+1 clocks after i_Sample.
REQ-025 SHALL ignore detections during HOLD for o_form_monitor and o_err_field, but still increment o_err_count and keep sticky set.
REQ-026 SHALL saturate o_err_count at 2^CNT_W-1.
REQ-027 SHALL give a detection priority over i_Clear in the same clock: sticky=1, count=1.
REQ-028 SHALL keep the EOF bit counter saturating at EOF_BITS-1.

Reset
REQ-029 SHALL on i_Reset force o_form_monitor=0, o_form_sticky=0, o_err_field=0, o_overload_req=0, o_err_count=0, FSM=IDLE, EOF counter=0, delay flops=recessive/0.
REQ-030 SHALL abort an in-progress HOLD immediately when reset occurs mid-hold.

Structure
REQ-031 SHALL take field codes (CRC_DELIM, ACK_DELIM, EOF, ERR_DELIM, OVL_DELIM) and FSM state encoding from shared package can_pkg.
REQ-032 SHALL place input delay in sub-module can_sync_delay, parametrised by width and SYNC_STAGES.

Verification
REQ-033 SHALL verify: field=10001, strobe with Data=0 -> o_form_monitor high 10 clocks starting 3 clocks after strobe, o_err_field=10001, count=1.
REQ-034 SHALL verify: EOF with 7 recessive bits -> no error, no overload.
REQ-035 SHALL verify: EOF bit 6 dominant -> o_overload_req one pulse, count unchanged; bit 3 dominant -> form error.
REQ-036 SHALL verify: second error during HOLD -> single 10-clock pulse, count=2, o_err_field unchanged.
REQ-037 SHALL verify: i_Clear and new detection in same clock -> sticky=1, count=1; CNT_W=2 with 5 errors -> count=3.
REQ-038 SHALL verify: reset at hold clock 4 -> all outputs 0 next clock; next error yields a full 10-clock pulse.
